// File: rtl/riscv_ifetch_ahb.sv
// riscv_ifetch_ahb
// Instruction-fetch bus interface: turns fetch-stage PC requests into single
// 32-bit AHB-Lite read transfers and returns the fetched parcels, in request
// order, through a small response FIFO.
//
// Ports
//   clk, rstn              clock, asynchronous active-low reset
//   if_nxt_pc              PC requested by the fetch stage
//   if_stall               fetch stage cannot accept a parcel
//   if_flush               discard every buffered and in-flight fetch
//   if_stall_nxt_pc        if_nxt_pc not consumed this cycle
//   if_parcel(_pc/_valid)  FIFO head: instruction bits, PC, per-16-bit valid
//   if_parcel_misaligned   head PC was not 4-byte aligned (no bus access made)
//   if_parcel_page_fault   head fetch ended in an AHB ERROR response
//   H*                     AHB-Lite master port (read-only, single transfers)
module riscv_ifetch_ahb #(
    parameter int                XLEN        = 64,
    parameter int                PARCEL_SIZE = 32,
    parameter int                FIFO_DEPTH  = 4,
    parameter logic [XLEN-1:0]   PC_INIT     = XLEN'(32'h8000_0000)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [XLEN-1:0]          if_nxt_pc,
    input  logic                     if_stall,
    input  logic                     if_flush,
    output logic                     if_stall_nxt_pc,
    output logic [PARCEL_SIZE-1:0]   if_parcel,
    output logic [XLEN-1:0]          if_parcel_pc,
    output logic [PARCEL_SIZE/16-1:0] if_parcel_valid,
    output logic                     if_parcel_misaligned,
    output logic                     if_parcel_page_fault,
    output logic                     HSEL,
    output logic [XLEN-1:0]          HADDR,
    output logic [PARCEL_SIZE-1:0]   HWDATA,
    input  logic [PARCEL_SIZE-1:0]   HRDATA,
    output logic                     HWRITE,
    output logic [2:0]               HSIZE,
    output logic [2:0]               HBURST,
    output logic [3:0]               HPROT,
    output logic [1:0]               HTRANS,
    output logic                     HMASTLOCK,
    input  logic                     HREADY,
    input  logic                     HRESP
);

    localparam int                     PW     = $clog2(FIFO_DEPTH);
    localparam int                     CW     = PW + 1;
    localparam int                     VW     = PARCEL_SIZE / 16;
    localparam logic [PARCEL_SIZE-1:0] NOP    = PARCEL_SIZE'(32'h0000_0013);
    localparam logic [1:0]             IDLE   = 2'b00;
    localparam logic [1:0]             NONSEQ = 2'b10;

    // Address-phase slot. r_as_mis marks a misaligned request that never goes
    // on the bus; it only travels through the slots to keep FIFO order.
    // r_as_cancel: transfer withdrawn during an ERROR response, replayed after.
    logic                   r_as_valid, r_as_mis, r_as_cancel, r_as_discard;
    logic [XLEN-1:0]        r_haddr;
    // Data-phase slot
    logic                   r_ds_valid, r_ds_mis, r_ds_discard;
    logic [XLEN-1:0]        r_ds_pc;
    // Response FIFO
    logic [PARCEL_SIZE-1:0] r_fifo_parcel [FIFO_DEPTH];
    logic [XLEN-1:0]        r_fifo_pc     [FIFO_DEPTH];
    logic                   r_fifo_mis    [FIFO_DEPTH];
    logic                   r_fifo_pf     [FIFO_DEPTH];
    logic [PW-1:0]          r_wptr, r_rptr;
    logic [CW-1:0]          r_count;

    logic                   w_ds_done, w_as_adv, w_as_to_ds, w_as_drop;
    logic                   w_err_first, w_err_busy, w_accept, w_mis_req;
    logic                   w_push, w_pop, w_nonempty;
    logic [CW:0]            w_occ;
    logic [PARCEL_SIZE-1:0] w_push_parcel;
    logic                   w_push_mis, w_push_pf;

    // A misaligned entry in the data slot has no bus phase, so it completes at once.
    assign w_ds_done   = r_ds_valid & (r_ds_mis | HREADY);
    assign w_as_adv    = r_as_valid & ~r_as_cancel &
                         (r_as_mis ? (~r_ds_valid | w_ds_done) : HREADY);
    // Entries with no bus transfer behind them simply die on a flush.
    assign w_as_drop   = r_as_valid & if_flush & (r_as_mis | r_as_cancel);
    assign w_as_to_ds  = w_as_adv & ~w_as_drop;
    assign w_err_first = r_ds_valid & ~r_ds_mis & HRESP & ~HREADY;
    assign w_err_busy  = (r_ds_valid & ~r_ds_mis & HRESP) | r_as_cancel;
    assign w_occ       = {1'b0, r_count} + {{CW{1'b0}}, r_as_valid} + {{CW{1'b0}}, r_ds_valid};
    assign w_mis_req   = |if_nxt_pc[1:0];
    assign w_accept    = rstn & ~if_stall & ~if_flush & ~w_err_busy &
                         (w_occ < (CW+1)'(FIFO_DEPTH)) & (~r_as_valid | w_as_adv);
    assign w_nonempty  = (r_count != {CW{1'b0}});
    assign w_push      = w_ds_done & ~r_ds_discard & ~if_flush;
    assign w_pop       = w_nonempty & ~if_stall & ~if_flush;

    assign if_stall_nxt_pc = ~w_accept;

    // AHB-Lite master outputs: read-only single word transfers
    assign HTRANS    = (r_as_valid & ~r_as_mis & ~r_as_cancel) ? NONSEQ : IDLE;
    assign HSEL      = (HTRANS != IDLE);
    assign HADDR     = r_haddr;
    assign HWDATA    = {PARCEL_SIZE{1'b0}};
    assign HWRITE    = 1'b0;
    assign HSIZE     = 3'b010;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b1100;
    assign HMASTLOCK = 1'b0;

    // Select the FIFO entry built from the completing data phase
    always_comb begin
        w_push_parcel = HRDATA;
        w_push_mis    = 1'b0;
        w_push_pf     = 1'b0;
        if (r_ds_mis) begin
            w_push_parcel = NOP;
            w_push_mis    = 1'b1;
        end else if (HRESP) begin
            w_push_parcel = NOP;
            w_push_pf     = 1'b1;
        end else begin
            w_push_parcel = HRDATA;
        end
    end

    // Address-phase slot
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_as_valid   <= 1'b0;
            r_as_mis     <= 1'b0;
            r_as_cancel  <= 1'b0;
            r_as_discard <= 1'b0;
            r_haddr      <= {XLEN{1'b0}};
        end else if (w_accept) begin
            r_as_valid   <= 1'b1;
            r_as_mis     <= w_mis_req;
            r_as_cancel  <= 1'b0;
            r_as_discard <= 1'b0;
            r_haddr      <= if_nxt_pc;
        end else if (w_as_drop | w_as_to_ds) begin
            r_as_valid   <= 1'b0;
            r_as_mis     <= 1'b0;
            r_as_cancel  <= 1'b0;
            r_as_discard <= 1'b0;
        end else if (r_as_valid) begin
            // A transfer in a wait state must stay on the bus; just mark it dead.
            if (if_flush) begin
                r_as_discard <= 1'b1;
            end
            // Two-cycle ERROR: go IDLE in its second cycle, reissue afterwards.
            if (w_err_first) begin
                r_as_cancel <= 1'b1;
            end else if (r_as_cancel & HREADY) begin
                r_as_cancel <= 1'b0;
            end
        end
    end

    // Data-phase slot
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ds_valid   <= 1'b0;
            r_ds_mis     <= 1'b0;
            r_ds_discard <= 1'b0;
            r_ds_pc      <= {XLEN{1'b0}};
        end else if (w_as_to_ds) begin
            r_ds_valid   <= 1'b1;
            r_ds_mis     <= r_as_mis;
            r_ds_discard <= r_as_discard | if_flush;
            r_ds_pc      <= r_haddr;
        end else if (w_ds_done) begin
            r_ds_valid   <= 1'b0;
            r_ds_mis     <= 1'b0;
            r_ds_discard <= 1'b0;
        end else if (r_ds_valid & if_flush) begin
            r_ds_discard <= 1'b1;
        end
    end

    // Response FIFO; flush resets the pointers, stale entries are never shown
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_parcel[i] <= NOP;
                r_fifo_pc[i]     <= {XLEN{1'b0}};
                r_fifo_mis[i]    <= 1'b0;
                r_fifo_pf[i]     <= 1'b0;
            end
        end else if (if_flush) begin
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_fifo_parcel[r_wptr] <= w_push_parcel;
                r_fifo_pc[r_wptr]     <= r_ds_pc;
                r_fifo_mis[r_wptr]    <= w_push_mis;
                r_fifo_pf[r_wptr]     <= w_push_pf;
                r_wptr                <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO head to fetch stage; NOP with clear flags when empty
    always_comb begin
        if_parcel_valid = {VW{w_nonempty}};
        if (w_nonempty) begin
            if_parcel            = r_fifo_parcel[r_rptr];
            if_parcel_pc         = r_fifo_pc[r_rptr];
            if_parcel_misaligned = r_fifo_mis[r_rptr];
            if_parcel_page_fault = r_fifo_pf[r_rptr];
        end else begin
            if_parcel            = NOP;
            if_parcel_pc         = {XLEN{1'b0}};
            if_parcel_misaligned = 1'b0;
            if_parcel_page_fault = 1'b0;
        end
    end

endmodule

// File: doc/riscv_ifetch_ahb.md
RISCV_IFETCH_AHB -- requirements
Module: riscv_ifetch_ahb

Interface
REQ-001 SHALL have parameters: XLEN, default 64, address/PC width; PARCEL_SIZE, default 32, parcel width and HRDATA width; FIFO_DEPTH, default 4 (power of 2), response-buffer entries; PC_INIT, default 'h8000_0000, documentation only.
REQ-002 SHALL have ports, one per line:
  clk  in  1  clock
  rstn  in  1  reset, asynchronous, active-low
  if_nxt_pc  in  XLEN  PC requested by fetch stage
  if_stall  in  1  fetch stage cannot accept a parcel
  if_flush  in  1  discard all buffered/in-flight fetches
  if_stall_nxt_pc  out  1  if_nxt_pc not consumed this cycle
  if_parcel  out  PARCEL_SIZE  fetched instruction bits
  if_parcel_pc  out  XLEN  PC of if_parcel
  if_parcel_valid  out  PARCEL_SIZE/16  per-16-bit parcel valid
  if_parcel_misaligned  out  1  parcel PC not 4-byte aligned
  if_parcel_page_fault  out  1  bus error on fetch
  HSEL  out  1;  HADDR  out  XLEN;  HWDATA  out  PARCEL_SIZE;  HRDATA  in  PARCEL_SIZE
  HWRITE  out  1;  HSIZE  out  3;  HBURST  out  3;  HPROT  out  4;  HTRANS  out  2;  HMASTLOCK  out  1
  HREADY  in  1;  HRESP  in  1

Function
REQ-003 SHALL be an AHB-Lite read-only master: HWRITE=0, HWDATA=0, HSIZE=3'b010, HBURST=SINGLE, HPROT=4'b1100, HMASTLOCK=0, HSEL=(HTRANS!=IDLE).
REQ-004 SHALL hold a registered address-phase slot (valid, HADDR) and data-phase slot (valid, pc, discard flag); HTRANS=NONSEQ when address slot valid, else IDLE.
REQ-005 Occupancy = FIFO count + address-slot valid + data-slot valid; a request SHALL be accepted when ~if_stall, ~if_flush, occupancy<FIFO_DEPTH, no ERROR response in progress, and address slot empty or HREADY=1.
REQ-006 if_stall_nxt_pc SHALL be combinationally the inverse of request acceptance.
REQ-007 Accepted aligned request (if_nxt_pc[1:0]==0) SHALL load the address slot; HTRANS=NONSEQ, HADDR=if_nxt_pc the next cycle.
REQ-008 Accepted misaligned request SHALL issue no bus transfer and SHALL push {NOP, if_nxt_pc, misaligned=1} into the FIFO after all older entries.
REQ-009 Address slot with HREADY=1 SHALL move to data slot; HADDR/HTRANS SHALL stay stable while HREADY=0.
REQ-010 Data slot with HREADY=1, HRESP=OKAY SHALL push {HRDATA, pc, 0, 0}; ERROR SHALL push {NOP, pc, page_fault=1}.
REQ-011 On first ERROR cycle (HRESP=1, HREADY=0) the pending address slot SHALL be cancelled (HTRANS=IDLE next cycle) and its request re-accepted later, not lost.
REQ-012 FIFO head SHALL drive outputs; if_parcel_valid=all-ones when non-empty, else 0; head popped each cycle if_parcel_valid!=0 and ~if_stall; in-order delivery.
REQ-013 if_flush SHALL empty the FIFO, set discard on the data slot (completes on bus, no push), set discard on an address slot in wait state (held per AHB, then discarded), and clear an idle address slot.
REQ-014 Simultaneous push and pop SHALL keep count unchanged; pointers wrap modulo FIFO_DEPTH; push into full FIFO SHALL be impossible by REQ-005.
REQ-015 When if_parcel_valid==0, if_parcel SHALL be NOP (32'h0000_0013) and flags 0.

Reset
REQ-016 rstn low SHALL asynchronously clear all slots, FIFO and pointers: HTRANS=IDLE, HADDR=0, if_parcel_valid=0, if_parcel=NOP, if_parcel_pc=0, flags 0, if_stall_nxt_pc=1 while reset asserted.
REQ-017 Reset mid-transfer SHALL abandon the transfer; first request after release issues a fresh NONSEQ.

Verification
REQ-018 Zero-wait stream: if_nxt_pc 0x8000_0000,+4,+8, HREADY=1 -> NONSEQ at 0x8000_0000 cycle 1; parcels in order, pc 0x8000_0000/04/08, valid=2'b11.
REQ-019 Wait states: HREADY low 3 cycles on 0x8000_0004 -> HADDR held 0x8000_0004, if_stall_nxt_pc=1, parcel delivered after HREADY high.
REQ-020 Bus error: HRESP ERROR two-cycle on 0x8000_0010 -> HTRANS IDLE second cycle, parcel NOP, pc 0x8000_0010, page_fault=1.
REQ-021 Misaligned: if_nxt_pc=0x8000_0002 -> no NONSEQ, parcel NOP, misaligned=1, pc 0x8000_0002.
REQ-022 Flush with data phase and 2 FIFO entries -> if_parcel_valid=0 next cycle, in-flight HRDATA dropped, next fetch from new if_nxt_pc only.
REQ-023 if_stall held 6 cycles -> occupancy caps at 4, if_stall_nxt_pc=1, no parcel lost or duplicated after release.
